// File: rtl/vpu_writeback.sv
// vpu_writeback: pairs VPU lane-1/lane-2 words into row writes to the UB.
// Lane 2 lags lane 1 by a cycle; each paired row is written at base+2*row.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   start_in             arms a job (IDLE only); samples base_addr_in, num_rows_in
//   vpu_data/valid_1/2   VPU lane words and strobes
//   ub_wr_*              registered UB write port (address + two data words)
//   busy_out             job in progress (COLLECT or DONE)
//   done_out             one-cycle pulse when the final row is written
//   err_out              sticky protocol error, cleared by reset or next start
module vpu_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] base_addr_in,
    input  logic [5:0]        num_rows_in,
    input  logic [DATA_W-1:0] vpu_data_1_in,
    input  logic [DATA_W-1:0] vpu_data_2_in,
    input  logic              vpu_valid_1_in,
    input  logic              vpu_valid_2_in,
    output logic              ub_wr_addr_valid_out,
    output logic [ADDR_W-1:0] ub_wr_addr_out,
    output logic [DATA_W-1:0] ub_wr_data_1_out,
    output logic [DATA_W-1:0] ub_wr_data_2_out,
    output logic              ub_wr_valid_1_out,
    output logic              ub_wr_valid_2_out,
    output logic              busy_out,
    output logic              done_out,
    output logic              err_out
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [5:0]        rows_q, rows_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              err_d;
    logic              wr_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rows_d      = rows_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_data_d = pend_data_q;
        err_d       = err_out;
        wr_d        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_in) begin
                    addr_d  = base_addr_in;
                    rows_d  = num_rows_in;
                    cnt_d   = 6'd0;
                    pend_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = (num_rows_in == 6'd0) ? DONE : COLLECT;
                end
            end

            COLLECT: begin
                // Lane 2 with nothing to pair against is dropped.
                if (vpu_valid_2_in && !pend_q) begin
                    err_d = 1'b1;
                end
                if (vpu_valid_2_in && pend_q) begin
                    wr_d   = 1'b1;
                    cnt_d  = cnt_q + 6'd1;
                    addr_d = addr_q + ADDR_W'(2);
                    pend_d = 1'b0;
                    if (cnt_q + 6'd1 == rows_q) begin
                        state_d = DONE;
                    end
                end
                // Lane 1 refills the slot; same-cycle lane 2 has already
                // drained it, otherwise this is an overrun.
                if (vpu_valid_1_in) begin
                    if (pend_q && !vpu_valid_2_in) begin
                        err_d = 1'b1;
                    end
                    pend_d      = 1'b1;
                    pend_data_d = vpu_data_1_in;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            rows_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            pend_data_q <= '0;
            err_out     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rows_q      <= rows_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_data_q <= pend_data_d;
            err_out     <= err_d;
        end
    end

    // Write port: strobes follow each pairing; data and address hold
    // their last value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ub_wr_addr_valid_out <= 1'b0;
            ub_wr_valid_1_out    <= 1'b0;
            ub_wr_valid_2_out    <= 1'b0;
            ub_wr_addr_out       <= '0;
            ub_wr_data_1_out     <= '0;
            ub_wr_data_2_out     <= '0;
        end else begin
            ub_wr_addr_valid_out <= wr_d;
            ub_wr_valid_1_out    <= wr_d;
            ub_wr_valid_2_out    <= wr_d;
            if (wr_d) begin
                ub_wr_addr_out   <= addr_q;
                ub_wr_data_1_out <= pend_data_q;
                ub_wr_data_2_out <= vpu_data_2_in;
            end
        end
    end

    assign busy_out = (state_q != IDLE);
    assign done_out = (state_q == DONE);

endmodule

// File: tb/tb_vpu_writeback.sv
// tb_vpu_writeback: scoreboard bench for vpu_writeback.
// Expected UB writes are queued by the stimulus and popped by a monitor.
module tb_vpu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_in;
    logic [5:0]  base_addr_in;
    logic [5:0]  num_rows_in;
    logic [15:0] vpu_data_1_in;
    logic [15:0] vpu_data_2_in;
    logic        vpu_valid_1_in;
    logic        vpu_valid_2_in;
    logic        ub_wr_addr_valid_out;
    logic [5:0]  ub_wr_addr_out;
    logic [15:0] ub_wr_data_1_out;
    logic [15:0] ub_wr_data_2_out;
    logic        ub_wr_valid_1_out;
    logic        ub_wr_valid_2_out;
    logic        busy_out;
    logic        done_out;
    logic        err_out;

    vpu_writeback #(.DATA_W(16), .ADDR_W(6)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start_in             (start_in),
        .base_addr_in         (base_addr_in),
        .num_rows_in          (num_rows_in),
        .vpu_data_1_in        (vpu_data_1_in),
        .vpu_data_2_in        (vpu_data_2_in),
        .vpu_valid_1_in       (vpu_valid_1_in),
        .vpu_valid_2_in       (vpu_valid_2_in),
        .ub_wr_addr_valid_out (ub_wr_addr_valid_out),
        .ub_wr_addr_out       (ub_wr_addr_out),
        .ub_wr_data_1_out     (ub_wr_data_1_out),
        .ub_wr_data_2_out     (ub_wr_data_2_out),
        .ub_wr_valid_1_out    (ub_wr_valid_1_out),
        .ub_wr_valid_2_out    (ub_wr_valid_2_out),
        .busy_out             (busy_out),
        .done_out             (done_out),
        .err_out              (err_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] d1;
        logic [15:0] d2;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Monitor: any write strobe must match the oldest queued write.
    always @(negedge clk) begin
        if (ub_wr_addr_valid_out || ub_wr_valid_1_out || ub_wr_valid_2_out) begin
            wr_t e;
            chk("strobe_v1", ub_wr_valid_1_out, 1);
            chk("strobe_v2", ub_wr_valid_2_out, 1);
            chk("strobe_av", ub_wr_addr_valid_out, 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", ub_wr_addr_out, e.addr);
                chk("wr_data1", ub_wr_data_1_out, e.d1);
                chk("wr_data2", ub_wr_data_2_out, e.d2);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic expect_wr(input int a, input logic [15:0] x,
                             input logic [15:0] y);
        wr_t e;
        e.addr = 6'(a % 64);
        e.d1   = x;
        e.d2   = y;
        e.cyc  = cyc + 1;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic st, input logic [5:0] b,
                         input logic [5:0] n, input logic v1,
                         input logic [15:0] a, input logic v2,
                         input logic [15:0] c);
        start_in       = st;
        base_addr_in   = b;
        num_rows_in    = n;
        vpu_valid_1_in = v1;
        vpu_data_1_in  = a;
        vpu_valid_2_in = v2;
        vpu_data_2_in  = c;
        @(posedge clk);
        #1;
        start_in       = 1'b0;
        vpu_valid_1_in = 1'b0;
        vpu_valid_2_in = 1'b0;
    endtask

    task automatic idle();
        drive(0, 6'($urandom), 6'($urandom), 0, 16'($urandom),
              0, 16'($urandom));
    endtask

    // Idle gaps mid-job, sometimes with a start pulse that must be ignored.
    task automatic gaps();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++) begin
            drive($urandom_range(0, 3) == 0, 6'($urandom), 6'($urandom),
                  0, 16'($urandom), 0, 16'($urandom));
        end
    endtask

    // Legal job with random data, gaps and lane overlap.
    task automatic run_job(input int base, input int rows);
        logic [15:0] d1 [64];
        logic [15:0] d2 [64];
        logic        ov;
        for (int r = 0; r < 64; r++) begin
            d1[r] = 16'($urandom);
            d2[r] = 16'($urandom);
        end
        drive(1, 6'(base), 6'(rows), 0, 16'($urandom), 0, 16'($urandom));
        chk("job_start_busy", busy_out, 1);
        chk("job_start_err", err_out, 0);
        gaps();
        drive(0, 6'($urandom), 6'($urandom), 1, d1[0], 0, 16'($urandom));
        for (int r = 0; r < rows; r++) begin
            gaps();
            ov = (r + 1 < rows) && ($urandom_range(0, 1) == 1);
            expect_wr(base + 2 * r, d1[r], d2[r]);
            drive(0, 6'($urandom), 6'($urandom), ov, d1[r+1], 1, d2[r]);
            if (r == rows - 1) begin
                chk("job_done", done_out, 1);
                chk("job_done_busy", busy_out, 1);
            end else begin
                chk("job_not_done", done_out, 0);
            end
            if (!ov && r + 1 < rows) begin
                gaps();
                drive(0, 6'($urandom), 6'($urandom), 1, d1[r+1],
                      0, 16'($urandom));
            end
        end
        // Start and lane strobes during DONE must be ignored.
        drive(1, 6'($urandom), 6'($urandom_range(1, 63)), 1,
              16'($urandom), 1, 16'($urandom));
        chk("job_end_busy", busy_out, 0);
        chk("job_end_done", done_out, 0);
        chk("job_end_err", err_out, 0);
    endtask

    initial begin
        #500000;
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        start_in       = 1'b0;
        base_addr_in   = '0;
        num_rows_in    = '0;
        vpu_data_1_in  = '0;
        vpu_data_2_in  = '0;
        vpu_valid_1_in = 1'b0;
        vpu_valid_2_in = 1'b0;
        #1 rst = 1'b0;
        #2;
        chk("rst_busy", busy_out, 0);
        chk("rst_done", done_out, 0);
        chk("rst_err", err_out, 0);
        chk("rst_strobes", {ub_wr_addr_valid_out, ub_wr_valid_1_out,
                            ub_wr_valid_2_out}, 0);
        chk("rst_addr", ub_wr_addr_out, 0);
        chk("rst_data", {ub_wr_data_1_out, ub_wr_data_2_out}, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Reference example: base 8, two rows, overlapped lanes.
        drive(1, 6'd8, 6'd2, 0, 16'h0, 0, 16'h0);
        chk("ex_busy", busy_out, 1);
        drive(0, 6'd0, 6'd0, 1, 16'h1111, 0, 16'h0);
        expect_wr(8, 16'h1111, 16'h2222);
        drive(0, 6'd0, 6'd0, 1, 16'h3333, 1, 16'h2222);
        chk("ex_done_c3", done_out, 0);
        expect_wr(10, 16'h3333, 16'h4444);
        drive(0, 6'd0, 6'd0, 0, 16'h0, 1, 16'h4444);
        chk("ex_done_c4", done_out, 1);
        idle();
        chk("ex_done_c5", done_out, 0);
        chk("ex_busy_c5", busy_out, 0);
        chk("ex_err", err_out, 0);

        // Address wrap past 63.
        run_job(62, 2);

        // Zero-row job: DONE straight after start, no writes.
        drive(1, 6'd5, 6'd0, 0, 16'h0, 0, 16'h0);
        chk("zero_busy", busy_out, 1);
        chk("zero_done", done_out, 1);
        idle();
        chk("zero_busy_end", busy_out, 0);
        chk("zero_done_end", done_out, 0);

        // Orphan lane 2: sticky error, row not counted.
        drive(1, 6'd4, 6'd2, 0, 16'h0, 0, 16'h0);
        drive(0, 6'd0, 6'd0, 0, 16'h0, 1, 16'hdead);
        chk("orphan_err", err_out, 1);
        idle();
        chk("orphan_err_sticky", err_out, 1);
        drive(0, 6'd0, 6'd0, 1, 16'ha001, 0, 16'h0);
        expect_wr(4, 16'ha001, 16'hb001);
        drive(0, 6'd0, 6'd0, 1, 16'ha002, 1, 16'hb001);
        expect_wr(6, 16'ha002, 16'hb002);
        drive(0, 6'd0, 6'd0, 0, 16'h0, 1, 16'hb002);
        chk("orphan_done", done_out, 1);
        chk("orphan_err_done", err_out, 1);
        idle();
        chk("orphan_err_idle", err_out, 1);
        drive(1, 6'd40, 6'd1, 0, 16'h0, 0, 16'h0);
        chk("start_clears_err", err_out, 0);
        drive(0, 6'd0, 6'd0, 1, 16'h5a5a, 0, 16'h0);
        expect_wr(40, 16'h5a5a, 16'ha5a5);
        drive(0, 6'd0, 6'd0, 0, 16'h0, 1, 16'ha5a5);
        chk("err_job_done", done_out, 1);
        idle();

        // Lane-1 overrun: error, newer word wins.
        drive(1, 6'd20, 6'd1, 0, 16'h0, 0, 16'h0);
        drive(0, 6'd0, 6'd0, 1, 16'h0aaa, 0, 16'h0);
        drive(0, 6'd0, 6'd0, 1, 16'h0bbb, 0, 16'h0);
        chk("overrun_err", err_out, 1);
        expect_wr(20, 16'h0bbb, 16'h0ccc);
        drive(0, 6'd0, 6'd0, 0, 16'h0, 1, 16'h0ccc);
        chk("overrun_done", done_out, 1);
        idle();

        // Lane traffic in IDLE: ignored, then a fresh job uses its own base.
        for (int i = 0; i < 4; i++) begin
            drive(0, 6'($urandom), 6'($urandom), 1, 16'($urandom),
                  1, 16'($urandom));
        end
        chk("idle_lanes_busy", busy_out, 0);
        chk("idle_lanes_err", err_out, 1);
        run_job(33, 3);

        // Asynchronous reset mid-job after one of three rows.
        drive(1, 6'd30, 6'd3, 0, 16'h0, 0, 16'h0);
        drive(0, 6'd0, 6'd0, 1, 16'h1234, 0, 16'h0);
        expect_wr(30, 16'h1234, 16'h5678);
        drive(0, 6'd0, 6'd0, 1, 16'h9abc, 1, 16'h5678);
        #5 rst = 1'b0;
        #1;
        chk("mid_rst_busy", busy_out, 0);
        chk("mid_rst_strobes", {ub_wr_addr_valid_out, ub_wr_valid_1_out,
                                ub_wr_valid_2_out}, 0);
        chk("mid_rst_addr", ub_wr_addr_out, 0);
        chk("mid_rst_data", {ub_wr_data_1_out, ub_wr_data_2_out}, 0);
        drive(0, 6'd0, 6'd0, 1, 16'h1111, 1, 16'h2222);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 6'd0, 6'd0, 1, 16'($urandom), 1, 16'($urandom));
        end
        chk("post_rst_busy", busy_out, 0);
        chk("post_rst_err", err_out, 0);
        drive(1, 6'd0, 6'd1, 0, 16'h0, 0, 16'h0);
        drive(0, 6'd0, 6'd0, 1, 16'hcafe, 0, 16'h0);
        expect_wr(0, 16'hcafe, 16'hbeef);
        drive(0, 6'd0, 6'd0, 0, 16'h0, 1, 16'hbeef);
        chk("post_rst_done", done_out, 1);
        idle();

        // Randomized jobs, including a maximum-length one.
        for (int j = 0; j < 12; j++) begin
            run_job($urandom_range(0, 63), $urandom_range(1, 12));
        end
        run_job($urandom_range(0, 63), 63);

        idle();
        idle();
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
